// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
// Shares the single-port instruction/data RAM between the instruction-fetch
// requester (IF) and the load/store requester (DM). One access is in flight
// at a time. Each access is alignment-checked, bounded by a timeout, and
// completed with a one-cycle done pulse (plus err) back to its requester.
module mem_access_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              RESET,
    // instruction-fetch requester
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic              if_err,
    output logic [DATA_W-1:0] if_rdata,
    // load/store requester
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [1:0]        dm_type,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic              dm_err,
    output logic [DATA_W-1:0] dm_rdata,
    // RAM handshake
    output logic              ram_en,
    output logic              ram_rw,
    output logic [1:0]        ram_type,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_moc,
    output logic              busy
);

    // Counter must be able to hold TIMEOUT itself.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] TYPE_BYTE = 2'b00;
    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] TYPE_WORD = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
    typedef enum logic {G_IF = 1'b0, G_DM = 1'b1} grant_t;

    state_t            state_q,      state_d;
    logic [CNT_W-1:0]  count_q,      count_d;
    grant_t            last_grant_q, last_grant_d;
    logic              ram_en_q,     ram_en_d;
    logic              ram_rw_q,     ram_rw_d;
    logic [1:0]        ram_type_q,   ram_type_d;
    logic [ADDR_W-1:0] ram_addr_q,   ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q,  ram_wdata_d;
    logic              busy_q,       busy_d;
    logic              if_done_q,    if_done_d;
    logic              if_err_q,     if_err_d;
    logic [DATA_W-1:0] if_rdata_q,   if_rdata_d;
    logic              dm_done_q,    dm_done_d;
    logic              dm_err_q,     dm_err_d;
    logic [DATA_W-1:0] dm_rdata_q,   dm_rdata_d;

    // Candidate request chosen in IDLE (only meaningful when a request is pending)
    grant_t            sel;
    logic              sel_rw;
    logic [1:0]        sel_type;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_bad;

    // Arbitration and alignment check of the pending requests.
    // NOTE: every signal written in an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        sel       = G_IF;
        sel_rw    = 1'b1;
        sel_type  = TYPE_WORD;
        sel_addr  = if_addr;
        sel_wdata = '0;
        sel_bad   = (if_addr[1:0] != 2'b00);
        // DM wins when alone, or on a tie when IF had the previous grant.
        if (dm_req && (!if_req || last_grant_q == G_IF)) begin
            sel       = G_DM;
            sel_rw    = ~dm_we;
            sel_type  = dm_type;
            sel_addr  = dm_addr;
            sel_wdata = dm_wdata;
            unique case (dm_type)
                TYPE_BYTE: sel_bad = 1'b0;
                TYPE_HALF: sel_bad = dm_addr[0];
                TYPE_WORD: sel_bad = (dm_addr[1:0] != 2'b00);
                default:   sel_bad = 1'b1;
            endcase
        end
    end

    // Next-state and next-output logic of the IDLE/ACCESS/RESP controller.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        ram_rw_d     = ram_rw_q;
        ram_type_d   = ram_type_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        // Done and err are pulses: cleared unless this cycle enters RESP.
        if_done_d    = 1'b0;
        if_err_d     = 1'b0;
        dm_done_d    = 1'b0;
        dm_err_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (if_req || dm_req) begin
                    last_grant_d = sel;
                    ram_rw_d     = sel_rw;
                    ram_type_d   = sel_type;
                    ram_addr_d   = sel_addr;
                    ram_wdata_d  = sel_wdata;
                    if (sel_bad) begin
                        // Rejected without touching the RAM.
                        state_d = S_RESP;
                        if (sel == G_DM) begin
                            dm_done_d  = 1'b1;
                            dm_err_d   = 1'b1;
                            dm_rdata_d = '0;
                        end else begin
                            if_done_d  = 1'b1;
                            if_err_d   = 1'b1;
                            if_rdata_d = '0;
                        end
                    end else begin
                        state_d = S_ACCESS;
                        count_d = '0;
                    end
                end
            end

            S_ACCESS: begin
                if (ram_moc || count_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_RESP;
                    // Writes and timeouts return zero data.
                    if (last_grant_q == G_DM) begin
                        dm_done_d  = 1'b1;
                        dm_err_d   = ~ram_moc;
                        dm_rdata_d = (ram_moc && ram_rw_q) ? ram_rdata : '0;
                    end else begin
                        if_done_d  = 1'b1;
                        if_err_d   = ~ram_moc;
                        if_rdata_d = (ram_moc && ram_rw_q) ? ram_rdata : '0;
                    end
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobe and busy are registered copies of the state being entered.
        ram_en_d = (state_d == S_ACCESS);
        busy_d   = (state_d != S_IDLE);
    end

    // Single state register for the controller and all registered outputs.
    // NOTE: sequential state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        // NOTE: reset is synchronous and clears every register, including the returned read data.
        if (!RESET) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            last_grant_q <= G_IF;
            ram_en_q     <= 1'b0;
            ram_rw_q     <= 1'b0;
            ram_type_q   <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            busy_q       <= 1'b0;
            if_done_q    <= 1'b0;
            if_err_q     <= 1'b0;
            if_rdata_q   <= '0;
            dm_done_q    <= 1'b0;
            dm_err_q     <= 1'b0;
            dm_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            ram_en_q     <= ram_en_d;
            ram_rw_q     <= ram_rw_d;
            ram_type_q   <= ram_type_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            busy_q       <= busy_d;
            if_done_q    <= if_done_d;
            if_err_q     <= if_err_d;
            if_rdata_q   <= if_rdata_d;
            dm_done_q    <= dm_done_d;
            dm_err_q     <= dm_err_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_rw    = ram_rw_q;
    assign ram_type  = ram_type_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = busy_q;
    assign if_done   = if_done_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign dm_done   = dm_done_q;
    assign dm_err    = dm_err_q;
    assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed testbench for mem_access_arbiter: reset, fetch, store, load,
// alignment rejects, tie arbitration, timeout and reset mid-access.
module tb_mem_access_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              Clk = 1'b0;
    logic              RESET;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done, if_err;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req, dm_we;
    logic [1:0]        dm_type;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_done, dm_err;
    logic [DATA_W-1:0] dm_rdata;
    logic              ram_en, ram_rw;
    logic [1:0]        ram_type;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_moc;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;

    mem_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(15)) dut (
        .Clk(Clk), .RESET(RESET),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_err(if_err), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_type(dm_type), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_err(dm_err), .dm_rdata(dm_rdata),
        .ram_en(ram_en), .ram_rw(ram_rw), .ram_type(ram_type), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_moc(ram_moc), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Flag bundle: {ram_en, busy, if_done, if_err, dm_done, dm_err}
    function automatic logic [5:0] flags();
        return {ram_en, busy, if_done, if_err, dm_done, dm_err};
    endfunction

    task automatic quiet_inputs();
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_type = 2'b00; dm_addr = '0; dm_wdata = '0;
        ram_moc = 1'b0; ram_rdata = '0;
    endtask

    task automatic apply_reset();
        quiet_inputs();
        RESET = 1'b0;
        step();
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        logic [112:0] obs;
        RESET = 1'b0;
        quiet_inputs();
        if_req = 1'b1; ram_moc = 1'b1; ram_rdata = 32'hFFFF_FFFF;
        step(); step();
        obs = {flags(), ram_rw, ram_type, ram_addr, ram_wdata, if_rdata, dm_rdata};
        vectors++;
        if (obs !== '0) begin
            $display("FAIL reset_outputs: got %h expected 0", obs); miscompares++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            $display("FAIL reset_busy: got %b expected 0", busy); miscompares++;
        end
        quiet_inputs();
        RESET = 1'b1;
        step();
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 8'h04;
        step();
        vectors++;
        if ({flags(), ram_rw, ram_type, ram_addr} !== {6'b110000, 1'b1, 2'b10, 8'h04}) begin
            $display("FAIL fetch_grant: got %b/%b/%b/%h expected 110000/1/10/04", flags(), ram_rw, ram_type, ram_addr);
            miscompares++;
        end
        if_req = 1'b0;
        step(); step();
        vectors++;
        if (flags() !== 6'b110000) begin
            $display("FAIL fetch_wait: got %b expected 110000", flags()); miscompares++;
        end
        ram_moc = 1'b1; ram_rdata = 32'h8C22_0000;
        step();
        vectors++;
        if ({flags(), if_rdata} !== {6'b011000, 32'h8C22_0000}) begin
            $display("FAIL fetch_done: got %b/%h expected 011000/8c220000", flags(), if_rdata); miscompares++;
        end
        ram_moc = 1'b0;
        step();
        vectors++;
        if (flags() !== 6'b000000) begin
            $display("FAIL fetch_idle: got %b expected 000000", flags()); miscompares++;
        end
    endtask

    task automatic test_store_byte();
        dm_req = 1'b1; dm_we = 1'b1; dm_type = 2'b00; dm_addr = 8'h07; dm_wdata = 32'h0000_00AB;
        step();
        vectors++;
        if ({flags(), ram_rw, ram_type, ram_addr, ram_wdata} !== {6'b110000, 1'b0, 2'b00, 8'h07, 32'h0000_00AB}) begin
            $display("FAIL store_grant: got %b/%b/%b/%h/%h expected 110000/0/00/07/000000ab",
                     flags(), ram_rw, ram_type, ram_addr, ram_wdata);
            miscompares++;
        end
        dm_req = 1'b0;
        ram_moc = 1'b1; ram_rdata = 32'hDEAD_BEEF;
        step();
        vectors++;
        if ({flags(), dm_rdata} !== {6'b010010, 32'h0}) begin
            $display("FAIL store_done: got %b/%h expected 010010/00000000", flags(), dm_rdata); miscompares++;
        end
        ram_moc = 1'b0;
        step();
    endtask

    task automatic test_load_half();
        dm_req = 1'b1; dm_we = 1'b0; dm_type = 2'b01; dm_addr = 8'h12;
        step();
        vectors++;
        if ({flags(), ram_rw, ram_type, ram_addr} !== {6'b110000, 1'b1, 2'b01, 8'h12}) begin
            $display("FAIL load_half_grant: got %b/%b/%b/%h expected 110000/1/01/12", flags(), ram_rw, ram_type, ram_addr);
            miscompares++;
        end
        dm_req = 1'b0;
        ram_moc = 1'b1; ram_rdata = 32'h0000_1234;
        step();
        vectors++;
        if ({flags(), dm_rdata} !== {6'b010010, 32'h0000_1234}) begin
            $display("FAIL load_half_done: got %b/%h expected 010010/00001234", flags(), dm_rdata); miscompares++;
        end
        ram_moc = 1'b0;
        step();
    endtask

    // One rejected request: no RAM strobe, error done right after the grant.
    task automatic reject_case(input string name, input logic is_if, input logic [1:0] typ,
                               input logic [ADDR_W-1:0] addr, input logic [5:0] exp_flags);
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            dm_req = 1'b1; dm_we = 1'b0; dm_type = typ; dm_addr = addr;
        end
        ram_moc = 1'b1;
        step();
        vectors++;
        if (flags() !== exp_flags) begin
            $display("FAIL %s_done: got %b expected %b", name, flags(), exp_flags); miscompares++;
        end
        if_req = 1'b0; dm_req = 1'b0; ram_moc = 1'b0;
        step();
        vectors++;
        if (flags() !== 6'b000000) begin
            $display("FAIL %s_after: got %b expected 000000", name, flags()); miscompares++;
        end
    endtask

    task automatic test_misaligned();
        reject_case("mis_word",  1'b0, 2'b10, 8'h06, 6'b010011);
        reject_case("ill_type",  1'b0, 2'b11, 8'h00, 6'b010011);
        reject_case("mis_half",  1'b0, 2'b01, 8'h13, 6'b010011);
        reject_case("mis_fetch", 1'b1, 2'b10, 8'h02, 6'b011100);
    endtask

    task automatic test_tie();
        apply_reset();
        step();
        if_req = 1'b1; if_addr = 8'h08;
        dm_req = 1'b1; dm_we = 1'b0; dm_type = 2'b10; dm_addr = 8'h10;
        step();
        vectors++;
        if ({flags(), ram_addr} !== {6'b110000, 8'h10}) begin
            $display("FAIL tie1_grant: got %b/%h expected 110000/10", flags(), ram_addr); miscompares++;
        end
        ram_moc = 1'b1; ram_rdata = 32'h1111_1111;
        step();
        vectors++;
        if ({flags(), dm_rdata} !== {6'b010010, 32'h1111_1111}) begin
            $display("FAIL tie1_done: got %b/%h expected 010010/11111111", flags(), dm_rdata); miscompares++;
        end
        ram_moc = 1'b0;
        step();
        vectors++;
        if (flags() !== 6'b000000) begin
            $display("FAIL tie_idle: got %b expected 000000", flags()); miscompares++;
        end
        step();
        vectors++;
        if ({flags(), ram_addr, ram_type} !== {6'b110000, 8'h08, 2'b10}) begin
            $display("FAIL tie2_grant: got %b/%h/%b expected 110000/08/10", flags(), ram_addr, ram_type); miscompares++;
        end
        if_req = 1'b0; dm_req = 1'b0;
        ram_moc = 1'b1; ram_rdata = 32'h2222_2222;
        step();
        vectors++;
        if ({flags(), if_rdata} !== {6'b011000, 32'h2222_2222}) begin
            $display("FAIL tie2_done: got %b/%h expected 011000/22222222", flags(), if_rdata); miscompares++;
        end
        ram_moc = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int bad_wait;
        dm_req = 1'b1; dm_we = 1'b0; dm_type = 2'b10; dm_addr = 8'h20;
        ram_moc = 1'b0; ram_rdata = 32'hFFFF_FFFF;
        step();
        dm_req = 1'b0;
        bad_wait = 0;
        // ACCESS cycles 1..15 must all keep the strobe up without a done pulse.
        if (flags() !== 6'b110000) bad_wait++;
        for (int i = 2; i <= 15; i++) begin
            step();
            if (flags() !== 6'b110000) bad_wait++;
        end
        vectors++;
        if (bad_wait !== 0) begin
            $display("FAIL timeout_wait: got %0d bad cycles expected 0", bad_wait); miscompares++;
        end
        step();
        vectors++;
        if ({flags(), dm_rdata} !== {6'b010011, 32'h0}) begin
            $display("FAIL timeout_done: got %b/%h expected 010011/00000000", flags(), dm_rdata); miscompares++;
        end
        step();
    endtask

    task automatic test_reset_mid_access();
        int seen_done;
        dm_req = 1'b1; dm_we = 1'b0; dm_type = 2'b10; dm_addr = 8'h24;
        step();
        dm_req = 1'b0;
        step(); step();
        RESET = 1'b0;
        step();
        RESET = 1'b1;
        vectors++;
        if ({flags(), ram_addr} !== {6'b000000, 8'h00}) begin
            $display("FAIL reset_mid_state: got %b/%h expected 000000/00", flags(), ram_addr); miscompares++;
        end
        // A completion arriving now belongs to nothing and must be ignored.
        ram_moc = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (flags() !== 6'b000000) seen_done++;
        end
        ram_moc = 1'b0;
        vectors++;
        if (seen_done !== 0) begin
            $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", seen_done); miscompares++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fetch();
        test_store_byte();
        test_load_half();
        test_misaligned();
        test_tie();
        test_timeout();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
